// File: rtl/simple_timer.sv
// Loadable countdown timer with one-shot and auto-reload modes.
// A registered done pulse marks each expiry; busy is decoded from the state register.
module simple_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             ena,
  input  logic             periodic,
  output logic [WIDTH-1:0] counter,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] r_counter;
  logic             r_done;

  logic             w_reload_zero;
  logic             w_last;

  assign w_reload_zero = (r_reload == '0);
  // Counter never sits at 0 while running, so "<= 1" is the expiry condition.
  assign w_last        = (r_counter <= WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_reload  <= '0;
      r_counter <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (set) begin
        r_reload  <= din;
        r_counter <= din;
        r_state   <= IDLE;
      end else if (start) begin
        if (w_reload_zero) begin
          r_counter <= '0;
          r_state   <= IDLE;
          r_done    <= 1'b1;
        end else begin
          r_counter <= r_reload;
          r_state   <= RUN;
        end
      end else if (r_state == RUN && ena) begin
        if (!w_last) begin
          r_counter <= r_counter - WIDTH'(1);
        end else begin
          r_done <= 1'b1;
          // periodic only matters here, at the expiry edge.
          if (periodic) begin
            r_counter <= r_reload;
          end else begin
            r_counter <= '0;
            r_state   <= IDLE;
          end
        end
      end
    end
  end

  assign counter = r_counter;
  assign busy    = (r_state == RUN);
  assign done    = r_done;

endmodule

// File: tb/tb_simple_timer.sv
// Directed self-checking bench for simple_timer: one-shot, periodic, pause/restart,
// zero reload, input priority and asynchronous reset.
module tb_simple_timer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             set;
  logic [WIDTH-1:0] din;
  logic             start;
  logic             ena;
  logic             periodic;
  logic [WIDTH-1:0] counter;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  simple_timer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set      (set),
    .din      (din),
    .start    (start),
    .ena      (ena),
    .periodic (periodic),
    .counter  (counter),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int c, input int b, input int d);
    check({tag, ".counter"}, 32'(counter), 32'(c));
    check({tag, ".busy"},    32'(busy),    32'(b));
    check({tag, ".done"},    32'(done),    32'(d));
  endtask

  int per_cnt[10]  = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};
  int per_done[10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; set = 1'b0; din = '0; start = 1'b0; ena = 1'b0; periodic = 1'b0;
    #3;
    check_out("reset", 0, 0, 0);
    #9 rst_n = 1'b1;
    tick();
    check_out("post_reset", 0, 0, 0);

    // One-shot, reload 5
    set = 1'b1; din = 8'd5;
    tick();
    check_out("os_set", 5, 0, 0);
    set = 1'b0; start = 1'b1; ena = 1'b1; periodic = 1'b0;
    tick();
    check_out("os_start", 5, 1, 0);
    start = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      tick();
      check_out($sformatf("os_cnt%0d", i), i, 1, 0);
    end
    tick();
    check_out("os_expire", 0, 0, 1);
    tick();
    check_out("os_after", 0, 0, 0);
    tick();
    check_out("os_idle_ena", 0, 0, 0);

    // Periodic, reload 3
    set = 1'b1; din = 8'd3;
    tick();
    set = 1'b0; start = 1'b1; periodic = 1'b1; ena = 1'b1;
    tick();
    check_out("per_start", 3, 1, 0);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out($sformatf("per_c%0d", i + 1), per_cnt[i], 1, per_done[i]);
    end

    // Periodic, reload 1: done every enabled cycle; then one-shot stop
    set = 1'b1; din = 8'd1;
    tick();
    set = 1'b0; start = 1'b1;
    tick();
    check_out("p1_start", 1, 1, 0);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("p1_c%0d", i), 1, 1, 1);
    end
    periodic = 1'b0;
    tick();
    check_out("p1_stop", 0, 0, 1);
    tick();
    check_out("p1_after", 0, 0, 0);

    // Pause and restart, reload 4
    set = 1'b1; din = 8'd4;
    tick();
    set = 1'b0; start = 1'b1; ena = 1'b1;
    tick();
    check_out("pr_start", 4, 1, 0);
    start = 1'b0;
    tick();
    check_out("pr_run1", 3, 1, 0);
    ena = 1'b0;
    tick();
    check_out("pr_hold1", 3, 1, 0);
    tick();
    check_out("pr_hold2", 3, 1, 0);
    ena = 1'b1;
    tick();
    check_out("pr_run2", 2, 1, 0);
    start = 1'b1;
    tick();
    check_out("pr_restart", 4, 1, 0);
    start = 1'b0;
    tick();
    check_out("pr_run3", 3, 1, 0);

    // Zero reload and set/start priority
    set = 1'b1; din = 8'd0;
    tick();
    check_out("z_set", 0, 0, 0);
    set = 1'b0; start = 1'b1;
    tick();
    check_out("z_start", 0, 0, 1);
    start = 1'b0;
    tick();
    check_out("z_after", 0, 0, 0);
    set = 1'b1; start = 1'b1; din = 8'd7; ena = 1'b1;
    tick();
    check_out("prio", 7, 0, 0);
    set = 1'b0; start = 1'b0;
    tick();
    check_out("prio_hold", 7, 0, 0);

    // Async reset mid-count at counter 3
    start = 1'b1;
    tick();
    check_out("ar_start", 7, 1, 0);
    start = 1'b0;
    for (int i = 6; i >= 3; i--) begin
      tick();
      check_out($sformatf("ar_cnt%0d", i), i, 1, 0);
    end
    #2 rst_n = 1'b0;
    #1;
    check_out("ar_async", 0, 0, 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("ar_post%0d", i), 0, 0, 0);
    end
    start = 1'b1;
    tick();
    check_out("ar_reload0", 0, 0, 1);
    start = 1'b0;
    tick();
    check_out("ar_end", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_timer.md
SIMPLE_TIMER -- requirements
Module: simple_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the bit width of din, counter and the internal reload register.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port set  input  1  when high, din SHALL be loaded into the reload register and into counter.
REQ-005 Port din  input  WIDTH  reload value, sampled only when set is high.
REQ-006 Port start  input  1  when high, SHALL begin or restart a countdown from the reload value.
REQ-007 Port ena  input  1  count enable; counting SHALL advance only when this is high.
REQ-008 Port periodic  input  1  selects the behaviour at expiry: 1 = auto-reload and keep running; 0 = one-shot.
REQ-009 Port counter  output  WIDTH  current count value, registered.
REQ-010 Port busy  output  1  high while the block is in state RUN.
REQ-011 Port done  output  1  registered one-cycle pulse at expiry.

Function
REQ-012 The block SHALL have exactly two states, IDLE and RUN; busy SHALL equal (state == RUN) and SHALL be decoded from the state register only.
REQ-013 Input priority on each rising edge SHALL be: set, then start, then ena.
REQ-014 set high in any state SHALL load reload <= din and counter <= din, force state to IDLE and drive done to 0; start and ena SHALL be ignored on that edge.
REQ-015 start high with set low and reload != 0 SHALL load counter <= reload and enter RUN, from either state (restart while in RUN); done SHALL be 0 on that edge.
REQ-016 start high with set low and reload == 0 SHALL set counter <= 0, keep or force state IDLE, and pulse done for one cycle.
REQ-017 In RUN with ena = 0 (and no set or start), counter and state SHALL hold and done SHALL be 0.
REQ-018 In RUN with ena = 1 and counter > 1, counter SHALL decrement by 1 and done SHALL be 0.
REQ-019 In RUN with ena = 1 and counter == 1, done SHALL be 1 for the next cycle only.
REQ-020 On that expiry edge with periodic = 1: counter <= reload and the block SHALL stay in RUN.
REQ-021 On that expiry edge with periodic = 0: counter <= 0 and the block SHALL go to IDLE.
REQ-022 periodic SHALL be sampled only on the expiry edge; changing it mid-count SHALL have no other effect.
REQ-023 Latency: with reload = N (N >= 1) and ena held high from the start edge, done SHALL go high after the Nth rising edge following the edge that sampled start.
REQ-024 Periodic mode with reload = N and ena held high SHALL give done pulses exactly N cycles apart.
REQ-025 Periodic mode with reload = 1 SHALL hold done high on every enabled cycle.
REQ-026 In IDLE, ena SHALL have no effect, and counter SHALL hold its value.
REQ-027 counter SHALL never wrap below 0: no decrement occurs from 0, and a value of 0 SHALL never be reached in RUN except on one-shot expiry.
REQ-028 done SHALL never be high for two consecutive cycles except in the case of REQ-025.

Reset
REQ-029 rst_n low SHALL immediately, without waiting for clk, force counter = 0, reload = 0, done = 0, state = IDLE and busy = 0.
REQ-030 Deassertion of rst_n SHALL take effect at the first rising clk edge after rst_n goes high.
REQ-031 A reset asserted mid-count SHALL abort the countdown with no done pulse.

Verification
REQ-032 Bench one-shot: set, din = 5; start; ena = 1, periodic = 0 -> counter 5,4,3,2,1,0; done high exactly one cycle, after the 5th edge; busy then 0.
REQ-033 Bench periodic: din = 3, periodic = 1, ena = 1 for 10 cycles -> done every 3rd cycle, counter sequence 3,2,1,3,2,1, busy stays 1.
REQ-034 Bench pause and restart: din = 4; toggle ena 1,0,0,1 mid-count -> counter holds while ena = 0; start at counter = 2 -> counter 4 on the next edge, no done pulse.
REQ-035 Bench zero and priority: din = 0 then start -> single done pulse, busy stays 0; set and start together with din = 7 -> counter 7, state IDLE, done 0.
REQ-036 Bench async reset: assert rst_n low between clock edges during RUN at counter = 3 -> all outputs 0 before the next edge; no done pulse after release.
